load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage (ALU result + rs2) and the word-addressed, synchronous-read data memory.
//  Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses.
//  Sub-word stores use a 2-cycle read-modify-write. Loads are byte/half extracted and sign/zero-extended.
//  Stalls the core via req_ready while a multi-cycle access is in flight.
// PARAMETERS
//  ADDRESS_WIDTH  16  word-index width of the data memory (2**ADDRESS_WIDTH words)
//  DATA_WIDTH     32  data word width; fixed at 32 (byte-lane logic assumes 4 lanes)
// PORTS
//  clk         in   1              rising-edge clock
//  rst         in   1              synchronous, active-high reset
//  req_valid   in   1              access request this cycle
//  req_ready   out  1              LSU can accept a request (state==IDLE)
//  req_we      in   1              1=store, 0=load
//  req_funct3  in   3              RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr    in   DATA_WIDTH     byte address (ALU result)
//  req_wdata   in   DATA_WIDTH     store data (rs2); low byte/half used for SB/SH
//  resp_valid  out  1              one-cycle pulse: access complete
//  resp_err    out  1              with resp_valid: misaligned or illegal funct3
//  resp_rdata  out  DATA_WIDTH     extended load result; 0 for stores and errors
//  mem_addr    out  ADDRESS_WIDTH  word index = byte_addr[ADDRESS_WIDTH+1:2]
//  mem_wen     out  1              memory write enable
//  mem_wdata   out  DATA_WIDTH     word written to memory
//  mem_rdata   in   DATA_WIDTH     memory read data; registered, valid the cycle after mem_addr is presented
// BEHAVIOUR
//  States: IDLE, LOAD_RD, RMW_RD. Handshake: accept = req_valid & req_ready.
//  Reset: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, captured request regs=0.
//  mem_wen is forced 0 in any cycle with rst=1, including mid-RMW; the pending access is dropped with no response.
//  Error check on accept (cycle N):
//   - H/HU/SH with addr[0]!=0, or W/SW with addr[1:0]!=0, is an error.
//   - Load funct3 in {011,110,111} or store funct3 >010 is an error.
//   - On error: no memory write; resp_valid=resp_err=1, resp_rdata=0 in N+1; stay IDLE.
//  SW (cycle N): mem_addr=word, mem_wen=1, mem_wdata=req_wdata; resp_valid in N+1; stay IDLE.
//  Load (cycle N): present mem_addr, mem_wen=0; capture addr[1:0], funct3; go LOAD_RD.
//   - LOAD_RD (N+1): select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend; register into resp_rdata.
//   - LOAD_RD then goes to IDLE. Total latency: resp_valid in N+2, and a new request may be accepted in N+2.
//  SB/SH (cycle N): present mem_addr, mem_wen=0; capture wdata, byte mask, funct3; go RMW_RD.
//   - RMW_RD (N+1): mem_addr held, mem_wen=1, mem_wdata = merge(mem_rdata, lane-shifted wdata, mask).
//   - Masks: SB=4'b0001<<addr[1:0]; SH=4'b0011<<addr[1:0].
//   - resp_valid in N+2, IDLE.
//  req_ready=0 in LOAD_RD and RMW_RD; req_valid there is ignored (upstream holds it).
//  Outside LOAD_RD/RMW_RD with no accept: mem_wen=0, mem_addr=req_addr word index (don't-care).
//  Back-to-back: store in N then load of the same word accepted in N+1 returns the new data (write committed at edge N+1).
//  Word index wraps modulo 2**ADDRESS_WIDTH; upper address bits are ignored, not an error.
//  resp_valid is never high for two consecutive cycles for one request; resp_err=0 whenever resp_valid=0.
// TESTING
//  1. Preload word 4=0x8899AABB; LB addr 0x13 -> resp_rdata=0xFFFFFF88 at N+2.
//     LBU addr 0x13 -> 0x00000088. LH addr 0x10 -> 0xFFFFAABB.
//  2. SB wdata=0x123456CC addr 0x11 onto word 4=0x8899AABB -> mem_wen only in N+1, word 4=0x8899CCBB.
//     req_ready low in N+1; resp_valid in N+2.
//  3. SW 0xDEADBEEF addr 0x20, then LW addr 0x20 in next cycle -> resp_rdata=0xDEADBEEF.
//     resp_valid at N+1 (store) and N+3 (load).
//  4. LW addr 0x22, SH addr 0x13, funct3=011 load -> each gives resp_valid=resp_err=1, resp_rdata=0.
//     No mem_wen, memory unchanged.
//  5. SH at 0x12; assert rst in the RMW_RD cycle -> mem_wen stays 0, word unchanged.
//     Next cycle state=IDLE, resp_valid=0, req_ready=1.
//  6. Random 2000-op load/store mix vs. byte-array model; hold req_valid under stall.
//     All rdata/memory match; one resp per accept.

Source files
------------

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Bridges the execute stage (byte address + store data) to a word-addressed
//   data memory with a one-cycle registered read. RV32I byte/half/word loads
//   and stores are turned into whole-word accesses:
//     - SW writes directly in the accept cycle.
//     - SB/SH read the word, merge the new lanes, and write it back a cycle
//       later (read-modify-write).
//     - Loads read the word and extract/extend the addressed lane.
//   Misaligned accesses and illegal funct3 codes complete immediately with an
//   error response and never touch memory.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_we, req_funct3       store flag and RV32I size/extension code
//   req_addr, req_wdata      byte address and store data
//   resp_valid/resp_err      one-cycle completion pulse and error flag
//   resp_rdata               extended load data (0 for stores and errors)
//   mem_addr/mem_wen         word index and write enable to the memory
//   mem_wdata/mem_rdata      memory write data and registered read data
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [DATA_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_wen,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_RD = 2'd1,
        RMW_RD  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]               off_q, off_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [3:0]               mask_q, mask_d;
    logic                     resp_valid_q, resp_valid_d;
    logic                     resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;

    logic [ADDRESS_WIDTH-1:0] req_word;
    logic [1:0]               req_off;
    logic                     accept;
    logic                     f3_legal;
    logic                     misaligned;
    logic                     req_err;
    logic [DATA_WIDTH-1:0]    load_lane;
    logic [DATA_WIDTH-1:0]    load_data;
    logic [DATA_WIDTH-1:0]    merged;

    assign req_word  = req_addr[ADDRESS_WIDTH+1:2];
    assign req_off   = req_addr[1:0];
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;

    // funct3[1:0] encodes the access size for every legal code.
    always_comb begin
        f3_legal = 1'b0;
        if (req_we) begin
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end else begin
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        end
    end

    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
    assign req_err    = !f3_legal || misaligned;

    // Move the addressed lane down to bit 0, then extend.
    assign load_lane = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = load_lane;
        case (funct3_q)
            3'b000:  load_data = {{24{load_lane[7]}},  load_lane[7:0]};
            3'b001:  load_data = {{16{load_lane[15]}}, load_lane[15:0]};
            3'b100:  load_data = {24'd0, load_lane[7:0]};
            3'b101:  load_data = {16'd0, load_lane[15:0]};
            default: load_data = load_lane;
        endcase
    end

    // Byte-lane merge for sub-word stores: new lanes from the pre-shifted
    // store data, untouched lanes from the word just read.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = mask_q[gi] ? wdata_q[gi*8 +: 8]
                                                  : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        off_d        = off_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_addr     = req_word;
        mem_wen      = 1'b0;
        mem_wdata    = req_wdata;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        mem_wen      = 1'b1;
                        resp_valid_d = 1'b1;
                    end else begin
                        addr_d   = req_word;
                        off_d    = req_off;
                        funct3_d = req_funct3;
                        if (req_we) begin
                            wdata_d = req_wdata << {req_off, 3'b000};
                            mask_d  = (req_funct3[0] ? 4'b0011 : 4'b0001) << req_off;
                            state_d = RMW_RD;
                        end else begin
                            state_d = LOAD_RD;
                        end
                    end
                end
            end
            LOAD_RD: begin
                mem_addr     = addr_q;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
                state_d      = IDLE;
            end
            RMW_RD: begin
                mem_addr     = addr_q;
                mem_wen      = 1'b1;
                mem_wdata    = merged;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset landing mid read-modify-write must not corrupt memory.
        if (rst) begin
            mem_wen = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            off_q        <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory, plus a preload port used by the bench.
    logic [31:0] tb_mem [0:65535] = '{default: 32'd0};
    logic        pl_en = 1'b0;
    logic [15:0] pl_idx = 16'd0;
    logic [31:0] pl_data = 32'd0;
    always @(posedge clk) begin
        if (pl_en) tb_mem[pl_idx] <= pl_data;
        else if (mem_wen) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference byte model of the low 256 bytes.
    logic [7:0] mdl [0:255] = '{default: 8'd0};

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    int tests = 0;
    int fails = 0;
    int wen_count = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (mem_wen) wen_count++;
        if (!rst) begin
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check("resp_rdata", resp_rdata, e.data);
                    check("resp_cycle", cyc, e.due);
                    $display("[TB] resp cyc=%0d err=%0b rdata=%h", cyc, resp_err, resp_rdata);
                end
            end else if (resp_err) begin
                check("err_without_valid", 32'd1, 32'd0);
            end
        end
    end

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [7:0] a);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
        return (int'(a) % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [7:0] a);
        logic [31:0] v;
        int sz;
        sz = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < sz; i++) v = v | (32'(mdl[int'(a) + i]) << (8 * i));
        if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic preload(input logic [15:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_data = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
        if (idx < 16'd64)
            for (int i = 0; i < 4; i++) mdl[int'(idx) * 4 + i] = val[8*i +: 8];
    endtask

    // Drives one request, holding it until accepted; returns #1 after the
    // accepting edge with req_valid low.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit exp_resp, input bit upd,
                         input logic exp_err, input logic [31:0] exp_data);
        bit acc;
        int waits;
        int acc_cyc;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        acc = 1'b0; waits = 0; acc_cyc = 0;
        while (!acc) begin
            acc = req_ready;
            acc_cyc = cyc;
            @(posedge clk); #1;
            waits++;
            if (!acc && waits > 10) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        req_valid = 1'b0;
        $display("[TB] req cyc=%0d we=%0b f3=%0d addr=%h wdata=%h", acc_cyc, we, f3, addr, wd);
        if (acc && exp_resp) begin
            e.err  = exp_err;
            e.data = exp_data;
            e.due  = acc_cyc + ((exp_err || (we && f3 == 3'd2)) ? 1 : 2);
            sb_q.push_back(e);
        end
        if (acc && upd && we && !exp_err)
            for (int i = 0; i < size_of(f3); i++) mdl[int'(addr[7:0]) + i] = wd[8*i +: 8];
    endtask

    task automatic issue_rand();
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  a;
        logic [31:0] hi;
        logic        err;
        logic [31:0] data;
        int          r;
        we = 1'($urandom_range(0, 1));
        r  = $urandom_range(0, 15);
        if (r == 0) begin
            if (we) f3 = 3'($urandom_range(3, 7));
            else begin
                r  = $urandom_range(0, 2);
                f3 = (r == 0) ? 3'd3 : (r == 1) ? 3'd6 : 3'd7;
            end
        end else if (we) begin
            f3 = 3'($urandom_range(0, 2));
        end else begin
            r  = $urandom_range(0, 4);
            f3 = (r < 3) ? 3'(r) : 3'(r + 1);
        end
        a = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) a = a & ~8'(size_of(f3) - 1);
        hi = $urandom();
        err  = model_err(we, f3, a);
        data = (we || err) ? 32'd0 : model_load(f3, a);
        issue(we, f3, {hi[31:18], 10'd0, a}, $urandom(), 1'b1, 1'b1, err, data);
    endtask

    initial begin
        int w0;
        logic [31:0] mw;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'd0, resp_err},   32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);

        // 1. loads with extraction
        preload(16'd4, 32'h8899AABB);
        issue(1'b0, 3'b000, 32'h13, 32'd0, 1'b1, 1'b0, 1'b0, 32'hFFFFFF88);
        issue(1'b0, 3'b100, 32'h13, 32'd0, 1'b1, 1'b0, 1'b0, 32'h00000088);
        issue(1'b0, 3'b001, 32'h10, 32'd0, 1'b1, 1'b0, 1'b0, 32'hFFFFAABB);
        @(posedge clk); #1;

        // 2. SB read-modify-write
        w0 = wen_count;
        issue(1'b1, 3'b000, 32'h11, 32'h123456CC, 1'b1, 1'b1, 1'b0, 32'd0);
        check("t2_wen_n1",   {31'd0, mem_wen},   32'd1);
        check("t2_ready_n1", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t2_wen_count", wen_count, w0 + 1);
        check("t2_word4", tb_mem[4], 32'h8899CCBB);

        // 3. SW then LW back-to-back
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'd0);
        check("t3_sw_resp_n1", {31'd0, resp_valid}, 32'd1);
        issue(1'b0, 3'b010, 32'h20, 32'd0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // 4. errors
        w0 = wen_count;
        issue(1'b0, 3'b010, 32'h22, 32'd0,        1'b1, 1'b0, 1'b1, 32'd0);
        issue(1'b1, 3'b001, 32'h13, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'd0);
        issue(1'b0, 3'b011, 32'h10, 32'd0,        1'b1, 1'b0, 1'b1, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t4_no_wen", wen_count, w0);
        check("t4_word4", tb_mem[4], 32'h8899CCBB);

        // 5. reset during the RMW write cycle
        w0 = wen_count;
        issue(1'b1, 3'b001, 32'h12, 32'h00001111, 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        #1;
        check("t5_wen_in_rst", {31'd0, mem_wen}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("t5_req_ready",  {31'd0, req_ready},  32'd1);
        @(posedge clk); #1;
        check("t5_no_wen", wen_count, w0);
        check("t5_word4", tb_mem[4], 32'h8899CCBB);

        // 6. random mix against the byte model
        for (int n = 0; n < 2000; n++) begin
            issue_rand();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);
        for (int i = 0; i < 64; i++) begin
            mw = {mdl[4*i+3], mdl[4*i+2], mdl[4*i+1], mdl[4*i]};
            check($sformatf("mem_word_%0d", i), tb_mem[i], mw);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
